// File: rtl/comm_pkg.sv
// comm_pkg: shared constants and types for the copter command link.
// Opcodes, ack byte, decoded-frame struct and the FSM encodings used by comm_slave/uart_rx_byte.
package comm_pkg;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  localparam logic [7:0] POS_ACK   = 8'hA5;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] data;
  } cmd_frame_t;

  localparam logic [1:0] FRM_WAIT_CMD = 2'd0;
  localparam logic [1:0] FRM_WAIT_HI  = 2'd1;
  localparam logic [1:0] FRM_WAIT_LO  = 2'd2;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/comm_if.sv
// comm_if: command-processor side of comm_slave (decoded frame, response handshake, status pulses).
interface comm_if;
  import comm_pkg::*;

  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        tx_busy;
  logic        resp_sent;
  logic        frm_err;
  logic        ovr;

  modport slave (
    output cmd, data, cmd_rdy, tx_busy, resp_sent, frm_err, ovr,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport master (
    input  cmd, data, cmd_rdy, tx_busy, resp_sent, frm_err, ovr,
    output clr_cmd_rdy, resp, send_resp
  );

endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver (2-flop synchronizer, start detect, mid-bit sampling).
// The rx_idle output exists only when COMM_FRM_TIMEOUT_EN is defined.
//
// state    | meaning
// RX_IDLE  | armed, waiting for a 1->0 edge on the synchronized line
// RX_START | half-bit wait, then start re-check (high = glitch)
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | sampling stop bit, reports byte or framing error
module uart_rx_byte
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       rx_ferr
`ifdef COMM_FRM_TIMEOUT_EN
  ,
  output logic       rx_idle
`endif
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          baud_tc;

  assign baud_tc = (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rx_vld  = 1'b0;
    rx_ferr = 1'b0;
    if (state_q != RX_IDLE && !baud_tc) baud_d = baud_q - 1'b1;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d = RX_START;
          baud_d  = BAUD_HALF;
        end
      end
      RX_START: begin
        if (baud_tc) begin
          if (rx_s2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            baud_d  = BAUD_LAST;
            bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (baud_tc) begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          baud_d  = BAUD_LAST;
          if (bit_q == 4'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      RX_STOP: begin
        // Back to idle right at the stop sample so the next start edge is caught.
        if (baud_tc) begin
          state_d = RX_IDLE;
          rx_vld  = rx_s2_q;
          rx_ferr = !rx_s2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  assign rx_byte = shift_q;

`ifdef COMM_FRM_TIMEOUT_EN
  assign rx_idle = (state_q == RX_IDLE);
`endif

endmodule

// File: rtl/comm_slave.sv
// comm_slave: copter-side UART responder; 3-byte command frames in, one response byte out.
// Inter-byte frame timeout is built only when COMM_FRM_TIMEOUT_EN is defined.
//
// state        | meaning
// FRM_WAIT_CMD | expecting opcode byte
// FRM_WAIT_HI  | opcode shadowed, expecting data high byte
// FRM_WAIT_LO  | opcode/high shadowed, expecting data low byte
// TX_IDLE      | line high, accepting send_resp
// TX_START     | driving start bit
// TX_DATA      | driving 8 data bits, LSB first
// TX_STOP      | driving stop bit
module comm_slave
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
`ifdef COMM_FRM_TIMEOUT_EN
  ,
  parameter int FRM_TO   = 1_000_000
`endif
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  RX,
  output logic  TX,
  comm_if.slave bus
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_ferr;

`ifdef COMM_FRM_TIMEOUT_EN
  logic rx_idle;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx      (RX),
    .rx_byte (rx_byte),
    .rx_vld  (rx_vld),
    .rx_ferr (rx_ferr),
    .rx_idle (rx_idle)
  );
`else
  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx      (RX),
    .rx_byte (rx_byte),
    .rx_vld  (rx_vld),
    .rx_ferr (rx_ferr)
  );
`endif

  logic [1:0] frm_q, frm_d;
  logic [7:0] cmd_sh_q, cmd_sh_d;
  logic [7:0] hi_sh_q, hi_sh_d;
  cmd_frame_t frame_q, frame_d;
  logic       cmd_rdy_q, cmd_rdy_d;
  logic       frm_err_q, frm_err_d;
  logic       ovr_q, ovr_d;

`ifdef COMM_FRM_TIMEOUT_EN
  localparam int IW = $clog2(FRM_TO + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          frm_to;

  assign frm_to = (frm_q != FRM_WAIT_CMD) && rx_idle && (idle_q == IW'(FRM_TO - 1));
`endif

  always_comb begin
    frm_d     = frm_q;
    cmd_sh_d  = cmd_sh_q;
    hi_sh_d   = hi_sh_q;
    frame_d   = frame_q;
    cmd_rdy_d = cmd_rdy_q & ~bus.clr_cmd_rdy;
    frm_err_d = 1'b0;
    ovr_d     = 1'b0;
    if (rx_ferr) begin
      frm_d     = FRM_WAIT_CMD;
      frm_err_d = 1'b1;
    end else if (rx_vld) begin
      case (frm_q)
        FRM_WAIT_CMD: begin
          cmd_sh_d = rx_byte;
          frm_d    = FRM_WAIT_HI;
        end
        FRM_WAIT_HI: begin
          hi_sh_d = rx_byte;
          frm_d   = FRM_WAIT_LO;
        end
        FRM_WAIT_LO: begin
          // Completion overrides a same-cycle clear.
          frame_d.cmd  = cmd_sh_q;
          frame_d.data = {hi_sh_q, rx_byte};
          cmd_rdy_d    = 1'b1;
          ovr_d        = cmd_rdy_q;
          frm_d        = FRM_WAIT_CMD;
        end
        default: frm_d = FRM_WAIT_CMD;
      endcase
    end
`ifdef COMM_FRM_TIMEOUT_EN
    else if (frm_to) begin
      frm_d     = FRM_WAIT_CMD;
      cmd_sh_d  = '0;
      hi_sh_d   = '0;
      frm_err_d = 1'b1;
    end
    idle_d = (frm_q == FRM_WAIT_CMD || !rx_idle || frm_to) ? '0 : idle_q + 1'b1;
`endif
  end

  logic [1:0]    tx_st_q, tx_st_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    resp_q, resp_d;
  logic          tx_q, tx_d;
  logic          tx_busy_q, tx_busy_d;
  logic          resp_sent_q, resp_sent_d;
  logic          tx_baud_tc;

  assign tx_baud_tc = (tx_baud_q == '0);

  always_comb begin
    tx_st_d     = tx_st_q;
    tx_baud_d   = tx_baud_q;
    tx_bit_d    = tx_bit_q;
    resp_d      = resp_q;
    tx_d        = tx_q;
    tx_busy_d   = tx_busy_q;
    resp_sent_d = 1'b0;
    if (tx_st_q != TX_IDLE && !tx_baud_tc) tx_baud_d = tx_baud_q - 1'b1;
    case (tx_st_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (bus.send_resp) begin
          resp_d    = bus.resp;
          tx_busy_d = 1'b1;
          tx_d      = 1'b0;
          tx_st_d   = TX_START;
          tx_baud_d = BAUD_LAST;
        end
      end
      TX_START: begin
        if (tx_baud_tc) begin
          tx_st_d   = TX_DATA;
          tx_bit_d  = '0;
          tx_d      = resp_q[0];
          tx_baud_d = BAUD_LAST;
        end
      end
      TX_DATA: begin
        if (tx_baud_tc) begin
          tx_baud_d = BAUD_LAST;
          if (tx_bit_q == 4'd7) begin
            tx_st_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_d     = resp_q[tx_bit_d[2:0]];
          end
        end
      end
      TX_STOP: begin
        if (tx_baud_tc) begin
          tx_st_d     = TX_IDLE;
          tx_busy_d   = 1'b0;
          resp_sent_d = 1'b1;
          tx_d        = 1'b1;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_q       <= FRM_WAIT_CMD;
      cmd_sh_q    <= '0;
      hi_sh_q     <= '0;
      frame_q     <= '0;
      cmd_rdy_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      ovr_q       <= 1'b0;
      tx_st_q     <= TX_IDLE;
      tx_baud_q   <= '0;
      tx_bit_q    <= '0;
      resp_q      <= '0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
`ifdef COMM_FRM_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      frm_q       <= frm_d;
      cmd_sh_q    <= cmd_sh_d;
      hi_sh_q     <= hi_sh_d;
      frame_q     <= frame_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frm_err_q   <= frm_err_d;
      ovr_q       <= ovr_d;
      tx_st_q     <= tx_st_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      resp_q      <= resp_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
      resp_sent_q <= resp_sent_d;
`ifdef COMM_FRM_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign TX            = tx_q;
  assign bus.cmd       = frame_q.cmd;
  assign bus.data      = frame_q.data;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.tx_busy   = tx_busy_q;
  assign bus.resp_sent = resp_sent_q;
  assign bus.frm_err   = frm_err_q;
  assign bus.ovr       = ovr_q;

endmodule

// File: tb/tb_comm_slave.sv
// tb_comm_slave: directed bench for comm_slave at BAUD_DIV=16 (FRM_TO=400 with COMM_FRM_TIMEOUT_EN).
module tb_comm_slave;
  import comm_pkg::*;

  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;

  comm_if bus();

  comm_slave #(
    .BAUD_DIV(BD)
`ifdef COMM_FRM_TIMEOUT_EN
    , .FRM_TO(400)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .RX  (rx),
    .TX  (tx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  int rdy_rise_cyc = -1;
  logic rdy_prev = 1'b0;
  int frm_err_cnt = 0;
  int ovr_cnt = 0;
  int resp_sent_cnt = 0;
  int base;
  logic [9:0] exp_bits;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.cmd_rdy === 1'b1 && !rdy_prev) rdy_rise_cyc = cyc;
    rdy_prev = (bus.cmd_rdy === 1'b1);
    if (bus.frm_err === 1'b1)   frm_err_cnt++;
    if (bus.ovr === 1'b1)       ovr_cnt++;
    if (bus.resp_sent === 1'b1) resp_sent_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    last_start_cyc = cyc;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check_val("clr_rdy", 32'(bus.cmd_rdy), 0);
  endtask

  task automatic check_outputs_reset(input string tag);
    check_val({tag, "_tx"}, 32'(tx), 1);
    check_val({tag, "_cmd"}, 32'(bus.cmd), 0);
    check_val({tag, "_data"}, 32'(bus.data), 0);
    check_val({tag, "_rdy"}, 32'(bus.cmd_rdy), 0);
    check_val({tag, "_busy"}, 32'(bus.tx_busy), 0);
    check_val({tag, "_sent"}, 32'(bus.resp_sent), 0);
    check_val({tag, "_ferr"}, 32'(bus.frm_err), 0);
    check_val({tag, "_ovr"}, 32'(bus.ovr), 0);
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    bus.resp = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_reset("rst0");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // first frame: decode and cmd_rdy latency from the third start bit
    send_frame(SET_PTCH, 8'h00, 8'hFA);
    check_val("f1_cmd", 32'(bus.cmd), 32'h02);
    check_val("f1_data", 32'(bus.data), 32'h00FA);
    check_val("f1_rdy", 32'(bus.cmd_rdy), 1);
    check_val("f1_rdy_lat", 32'(rdy_rise_cyc - last_start_cyc), 155);
    pulse_clr();

    // response A5 with an ignored second send_resp mid-frame
    exp_bits = {1'b1, POS_ACK, 1'b0};
    base = resp_sent_cnt;
    @(negedge clk);
    bus.resp = POS_ACK;
    bus.send_resp = 1'b1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      bus.send_resp = (i == 50);
      if (i == 50) bus.resp = 8'h3C;
      check_val("tx_bit", 32'(tx), 32'(exp_bits[i / 16]));
      if (i == 159) check_val("tx_busy_end", 32'(bus.tx_busy), 1);
    end
    @(negedge clk);
    check_val("tx_busy_fall", 32'(bus.tx_busy), 0);
    check_val("resp_sent", 32'(bus.resp_sent), 1);
    check_val("tx_idle", 32'(tx), 1);
    bus.resp = 8'h0F;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    check_val("tx_b2b_start", 32'(tx), 0);
    check_val("tx_b2b_busy", 32'(bus.tx_busy), 1);
    repeat (165) @(negedge clk);
    check_val("resp_sent_cnt", 32'(resp_sent_cnt - base), 2);
    check_val("tx_b2b_idle", 32'(tx), 1);

    // overrun: second frame without clearing
    send_frame(SET_YAW, 8'h00, 8'hFC);
    check_val("f2_cmd", 32'(bus.cmd), 32'h04);
    check_val("f2_data", 32'(bus.data), 32'h00FC);
    base = ovr_cnt;
    send_frame(SET_THRST, 8'h12, 8'h34);
    check_val("f3_cmd", 32'(bus.cmd), 32'h05);
    check_val("f3_data", 32'(bus.data), 32'h1234);
    check_val("f3_rdy", 32'(bus.cmd_rdy), 1);
    check_val("f3_ovr_cnt", 32'(ovr_cnt - base), 1);

    // clear coincident with completion: completion wins
    send_byte(CALIBRATE, 1'b1);
    send_byte(8'hAB, 1'b1);
    fork
      send_byte(8'hCD, 1'b1);
      begin
        repeat (155) @(negedge clk);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
      end
    join
    check_val("f4_rdy", 32'(bus.cmd_rdy), 1);
    check_val("f4_cmd", 32'(bus.cmd), 32'h06);
    check_val("f4_data", 32'(bus.data), 32'hABCD);

    // bad stop bit on second byte, then a clean frame
    pulse_clr();
    base = frm_err_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    check_val("stop_ferr_cnt", 32'(frm_err_cnt - base), 1);
    send_frame(REQ_BATT, 8'h00, 8'h00);
    check_val("f5_cmd", 32'(bus.cmd), 32'h01);
    check_val("f5_data", 32'(bus.data), 32'h0000);
    check_val("f5_rdy", 32'(bus.cmd_rdy), 1);

    // long idle after an opcode
    pulse_clr();
    base = frm_err_cnt;
    send_byte(SET_ROLL, 1'b1);
    repeat (400) @(negedge clk);
    send_frame(EMER_LAND, 8'h00, 8'h00);
`ifdef COMM_FRM_TIMEOUT_EN
    check_val("to_cmd", 32'(bus.cmd), 32'h07);
    check_val("to_data", 32'(bus.data), 32'h0000);
    check_val("to_ferr_cnt", 32'(frm_err_cnt - base), 1);
`else
    check_val("to_cmd", 32'(bus.cmd), 32'h03);
    check_val("to_data", 32'(bus.data), 32'h0700);
    check_val("to_ferr_cnt", 32'(frm_err_cnt - base), 0);
`endif
    check_val("to_rdy", 32'(bus.cmd_rdy), 1);

    // reset mid RX byte and mid TX byte
    send_byte(CALIBRATE, 1'b1);
    @(negedge clk);
    bus.resp = POS_ACK;
    bus.send_resp = 1'b1;
    rx = 1'b0;
    @(negedge clk);
    bus.send_resp = 1'b0;
    repeat (40) @(negedge clk);
    check_val("pre_rst_busy", 32'(bus.tx_busy), 1);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check_outputs_reset("rst1");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    base = frm_err_cnt;
    send_frame(MTRS_OFF, 8'hBE, 8'hEF);
    check_val("f6_cmd", 32'(bus.cmd), 32'h08);
    check_val("f6_data", 32'(bus.data), 32'hBEEF);
    check_val("f6_rdy", 32'(bus.cmd_rdy), 1);
    check_val("f6_ferr_cnt", 32'(frm_err_cnt - base), 0);
    check_val("f6_tx", 32'(tx), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
